// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states
// and the wait-counter width.
package dmem_pkg;

    localparam logic [1:0] MEM_SIZE_B = 2'b00;
    localparam logic [1:0] MEM_SIZE_H = 2'b01;
    localparam logic [1:0] MEM_SIZE_W = 2'b10;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the data memory: byte enables, store-data replication,
// load-data extraction and misalignment detection (DMEM_ALIGN_CHECK_EN).
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext,
    output logic        misaligned
);

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        be         = 4'b0000;
        wdata_rep  = '0;
        rdata_ext  = '0;
        misaligned = 1'b0;
        case (size)
            MEM_SIZE_B: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {24'b0, rword[8*addr_lo +: 8]};
            end
            MEM_SIZE_H: begin
                // Only addr[1] picks the half; addr[0] is either flagged or dropped.
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {16'b0, (addr_lo[1] ? rword[31:16] : rword[15:0])};
`ifdef DMEM_ALIGN_CHECK_EN
                misaligned = addr_lo[0];
`endif
            end
            default: begin
                be        = 4'b1111;
                wdata_rep = wdata;
                rdata_ext = rword;
`ifdef DMEM_ALIGN_CHECK_EN
                misaligned = (addr_lo != 2'b00);
`endif
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory slave: word RAM with byte/half/word access, WAIT_CYCLES
// wait states and a pipeline stall; DMEM_ALIGN_CHECK_EN enables misalignment traps.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_memReq,
    input  logic        i_memWrite,
    input  logic [1:0]  i_memSize,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_valid,
    output logic        o_stall,
    output logic        o_misaligned
);

    logic [31:0]       mem [0:(2**ADDR_W)-1];
    state_t            state;
    logic [CNT_W-1:0]  cnt;

    logic [ADDR_W-1:0] idx;
    logic [31:0]       rword;
    logic [3:0]        be;
    logic [31:0]       wdata_rep;
    logic [31:0]       rdata_ext;
    logic              mis;
    logic              commit;
    logic              unused_addr;

    // Upper address bits are intentionally dropped so accesses wrap around the RAM.
    assign idx         = i_addr[ADDR_W+1:2];
    assign unused_addr = ^i_addr[31:ADDR_W+2];
    assign rword       = mem[idx];

    dmem_lane_align u_align (
        .size       (i_memSize),
        .addr_lo    (i_addr[1:0]),
        .wdata      (i_wdata),
        .rword      (rword),
        .be         (be),
        .wdata_rep  (wdata_rep),
        .rdata_ext  (rdata_ext),
        .misaligned (mis)
    );

    always_comb begin
        commit = 1'b0;
        case (state)
            IDLE:    commit = i_memReq && (WAIT_CYCLES == 0);
            BUSY:    commit = (cnt == '0);
            default: commit = 1'b0;
        endcase
    end

    assign o_stall = (state == IDLE) ? i_memReq : (state == BUSY);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            o_rdata      <= '0;
            o_valid      <= 1'b0;
            o_misaligned <= 1'b0;
        end else begin
            o_valid      <= 1'b0;
            o_misaligned <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_memReq) begin
                        if (WAIT_CYCLES == 0) begin
                            state <= DONE;
                        end else begin
                            state <= BUSY;
                            cnt   <= CNT_W'(WAIT_CYCLES - 1);
                        end
                    end
                end
                BUSY: begin
                    if (cnt == '0) state <= DONE;
                    else           cnt   <= cnt - CNT_W'(1);
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
            if (commit) begin
                o_valid      <= 1'b1;
                o_misaligned <= mis;
                o_rdata      <= (i_memWrite || mis) ? 32'h0 : rdata_ext;
            end
        end
    end

    // NOTE: the RAM array is never reset; contents survive reset and only state is cleared.
    always_ff @(posedge clk) begin
        if (commit && !reset && i_memWrite && !mis) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a reference word-memory model predicts
// every access; predictions are queued on issue and compared on o_valid.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int ADDR_W      = 10;
    localparam int WAIT_CYCLES = 1;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_memReq;
    logic        i_memWrite;
    logic [1:0]  i_memSize;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic [31:0] o_rdata;
    logic        o_valid;
    logic        o_stall;
    logic        o_misaligned;

    logic [31:0] model [0:(2**ADDR_W)-1];
    exp_t        sb [$];
    int          n_vec = 0;
    int          n_err = 0;

    dmem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT_CYCLES)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_memReq     (i_memReq),
        .i_memWrite   (i_memWrite),
        .i_memSize    (i_memSize),
        .i_addr       (i_addr),
        .i_wdata      (i_wdata),
        .o_rdata      (o_rdata),
        .o_valid      (o_valid),
        .o_stall      (o_stall),
        .o_misaligned (o_misaligned)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    // Reference behaviour of one access; updates the model RAM for stores.
    function automatic exp_t predict(input logic wr, input logic [1:0] sz,
                                     input logic [31:0] addr, input logic [31:0] wd);
        exp_t        e;
        int          w;
        logic [1:0]  lo;
        logic        is_word;
        logic [31:0] word;
        w       = int'(addr[ADDR_W+1:2]);
        lo      = addr[1:0];
        is_word = sz[1];
        e.rdata = 32'h0;
        e.mis   = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
        e.mis = (sz == MEM_SIZE_H && lo[0]) || (is_word && lo != 2'b00);
`else
        if (sz == MEM_SIZE_H) lo[0] = 1'b0;
        if (is_word) lo = 2'b00;
`endif
        if (e.mis) return e;
        word = model[w];
        if (wr) begin
            if (is_word)                word = wd;
            else if (sz == MEM_SIZE_H)  word[8*lo +: 16] = wd[15:0];
            else                        word[8*lo +: 8]  = wd[7:0];
            model[w] = word;
        end else begin
            if (is_word)                e.rdata = word;
            else if (sz == MEM_SIZE_H)  e.rdata = (word >> (8*lo)) & 32'h0000_FFFF;
            else                        e.rdata = (word >> (8*lo)) & 32'h0000_00FF;
        end
        return e;
    endfunction

    task automatic access(input logic wr, input logic [1:0] sz, input logic [31:0] addr,
                          input logic [31:0] wd, input string tag);
        exp_t e;
        int   stalls;
        bit   got;
        sb.push_back(predict(wr, sz, addr, wd));
        @(negedge clk);
        i_memReq   = 1'b1;
        i_memWrite = wr;
        i_memSize  = sz;
        i_addr     = addr;
        i_wdata    = wd;
        stalls     = 0;
        got        = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            #1;
            if (o_valid) got = 1'b1;
            else begin
                if (o_stall) stalls++;
                @(negedge clk);
            end
        end
        e = sb.pop_front();
        if (!got) begin
            check({tag, " valid timeout"}, 32'd0, 32'd1);
        end else begin
            check({tag, " rdata"}, o_rdata, e.rdata);
            check({tag, " misaligned"}, 32'(o_misaligned), 32'(e.mis));
            check({tag, " stall in done"}, 32'(o_stall), 32'd0);
            check({tag, " stall cycles"}, stalls, WAIT_CYCLES + 1);
        end
        i_memReq = 1'b0;
        @(negedge clk);
        #1;
        check({tag, " valid pulse width"}, 32'(o_valid), 32'd0);
        check({tag, " misaligned after done"}, 32'(o_misaligned), 32'd0);
        check({tag, " rdata hold"}, o_rdata, e.rdata);
    endtask

    initial begin
        reset      = 1'b1;
        i_memReq   = 1'b0;
        i_memWrite = 1'b0;
        i_memSize  = MEM_SIZE_W;
        i_addr     = '0;
        i_wdata    = '0;
        repeat (3) @(negedge clk);
        #1;
        check("reset valid", 32'(o_valid), 32'd0);
        check("reset stall", 32'(o_stall), 32'd0);
        check("reset misaligned", 32'(o_misaligned), 32'd0);
        check("reset rdata", o_rdata, 32'd0);
        reset = 1'b0;

        access(1, MEM_SIZE_W, 32'h10, 32'hDEAD_BEEF, "st w 10");
        access(0, MEM_SIZE_W, 32'h10, 32'h0, "ld w 10");

        access(1, MEM_SIZE_B, 32'h20, 32'hFFFF_FF11, "st b 20");
        access(1, MEM_SIZE_B, 32'h21, 32'h0000_0022, "st b 21");
        access(1, MEM_SIZE_B, 32'h22, 32'h0000_0033, "st b 22");
        access(1, MEM_SIZE_B, 32'h23, 32'hABCD_EF44, "st b 23");
        access(0, MEM_SIZE_W, 32'h20, 32'h0, "ld w 20");
        access(0, MEM_SIZE_H, 32'h22, 32'h0, "ld h 22");

        access(1, MEM_SIZE_W, 32'h30, 32'hFFFF_FFFF, "st w 30");
        access(1, MEM_SIZE_H, 32'h32, 32'h1234_ABCD, "st h 32");
        access(0, MEM_SIZE_W, 32'h30, 32'h0, "ld w 30");
        access(0, MEM_SIZE_B, 32'h33, 32'h0, "ld b 33");
        access(0, 2'b11,      32'h30, 32'h0, "ld size11 30");

        access(1, MEM_SIZE_W, 32'h1000, 32'h1234_5678, "st w 1000");
        access(0, MEM_SIZE_W, 32'h0000, 32'h0, "ld w 0 wrap");

        // Store aborted by reset in BUSY, which is also its commit edge.
        access(1, MEM_SIZE_W, 32'h40, 32'hCAFE_F00D, "st w 40");
        @(negedge clk);
        i_memReq   = 1'b1;
        i_memWrite = 1'b1;
        i_memSize  = MEM_SIZE_W;
        i_addr     = 32'h40;
        i_wdata    = 32'h5555_5555;
        #1;
        check("abort idle stall", 32'(o_stall), 32'd1);
        @(negedge clk);
        #1;
        check("abort busy stall", 32'(o_stall), 32'd1);
        reset    = 1'b1;
        i_memReq = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort stall", 32'(o_stall), 32'd0);
        check("abort valid", 32'(o_valid), 32'd0);
        check("abort rdata", o_rdata, 32'd0);
        access(0, MEM_SIZE_W, 32'h40, 32'h0, "ld w 40 after abort");

        access(1, MEM_SIZE_W, 32'h41, 32'h9988_7766, "st w 41");
        access(0, MEM_SIZE_W, 32'h40, 32'h0, "ld w 40 after 41");
        access(1, MEM_SIZE_H, 32'h45, 32'h0000_BEEF, "st h 45");
        access(0, MEM_SIZE_W, 32'h44, 32'h0, "ld w 44");

        for (int i = 0; i < 16; i++)
            access(1, MEM_SIZE_W, 32'h400 + 32'(4*i), $urandom, "prefill");
        for (int i = 0; i < 24; i++)
            access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   32'h400 + 32'($urandom_range(0, 63)), $urandom, "random");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory slave on the far end of the pipeline's MEM-stage request interface (memReq, memWrite, memSize, address, write data).
- Holds a word-organised synchronous RAM and serves byte, halfword and word loads and stores with a configurable number of wait states.
- Drives a stall back to the hazard unit so that the pipeline freezes while an access is outstanding.
- Load data is returned right-justified and zero-extended; the datapath does sign extension.

Parameters:
- ADDR_W, 10, word-index width; RAM depth is 2**ADDR_W 32-bit words.
- WAIT_CYCLES, 1, extra busy cycles per access (0..15).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- i_memReq  in  1  access request; held stable by the pipeline while o_stall=1
- i_memWrite  in  1  1=store, 0=load
- i_memSize  in  2  00=byte, 01=half, 10=word, 11=treated as word
- i_addr  in  32  byte address
- i_wdata  in  32  store data, right-justified
- o_rdata  out  32  load data, right-justified, zero-extended
- o_valid  out  1  access completes this cycle
- o_stall  out  1  freeze the IF..MEM pipeline registers
- o_misaligned  out  1  misaligned-access flag; tied 0 when the option is out

Behaviour:
- States are IDLE, BUSY and DONE. A 4-bit wait counter is used.
- Reset: state=IDLE, counter=0, o_rdata=0, o_valid=0, o_misaligned=0. RAM contents are not cleared.
- IDLE:
  - o_stall = i_memReq (combinational), o_valid=0.
  - If i_memReq=1 and WAIT_CYCLES=0, go to DONE and commit the access at this edge.
  - If i_memReq=1 and WAIT_CYCLES>0, go to BUSY with counter=WAIT_CYCLES-1.
- BUSY:
  - o_stall=1.
  - If counter=0, go to DONE and commit the access at this edge; otherwise decrement the counter.
- DONE:
  - o_stall=0, o_valid=1, o_rdata valid. The pipeline advances at the end of this cycle.
  - i_memReq is ignored here (it is the retiring request). Next state is IDLE.
- Access latency: request to o_valid is WAIT_CYCLES+1 cycles. Back-to-back requests pay a full access each, with one IDLE cycle between DONE and the next acceptance.
- Commit (store):
  - Write only the enabled byte lanes of word addr[ADDR_W+1:2].
  - byte: lane addr[1:0].
  - half: lanes {addr[1],0} and {addr[1],1}.
  - word: all four lanes.
  - Store data is taken from the low bits of i_wdata and replicated into the selected lanes.
- Commit (load): the selected lanes are shifted to bit 0, upper bits are zeroed, and the result is registered into o_rdata. For stores, o_rdata=0.
- Address range: upper address bits above ADDR_W+1 are ignored, so addresses wrap modulo the RAM size.
- o_rdata holds its value until the next commit.
- Reset mid-access, in BUSY or DONE: return to IDLE. A pending store is not committed if reset coincides with its commit edge.

Optional Feature:
- Macro: DMEM_ALIGN_CHECK_EN.
- Defined:
  - A half access with addr[0]=1, or a word access with addr[1:0]!=0, is misaligned.
  - It still follows the full IDLE/BUSY/DONE timing.
  - At commit the store is suppressed and o_rdata=0.
  - o_misaligned=1 in DONE only.
- Undefined:
  - Offending low address bits are forced to zero: half uses addr[1] only, word ignores addr[1:0].
  - o_misaligned is constant 0.

Decomposition:
- Package dmem_pkg:
  - MEM_SIZE_B=2'b00, MEM_SIZE_H=2'b01, MEM_SIZE_W=2'b10.
  - State encoding: IDLE=2'd0, BUSY=2'd1, DONE=2'd2.
  - Wait-counter width constant 4.
- Sub-module dmem_lane_align (combinational), inputs size and addr[1:0], outputs:
  - 4-bit byte enable;
  - lane-replicated write data;
  - extracted and zero-extended read data;
  - misaligned flag.
  The FSM, counter and RAM stay in dmem_responder.

Test Plan:
- WAIT_CYCLES=1, word store 0xDEADBEEF to 0x10, then word load 0x10:
  - o_stall=1 for exactly 2 cycles per access;
  - o_valid pulses one cycle per access;
  - load o_rdata=0xDEADBEEF.
- Byte stores 0x11/0x22/0x33/0x44 to 0x20..0x23, then word load 0x20 -> 0x44332211. Half load 0x22 -> 0x00004433.
- Half store 0xABCD to 0x32 over a word pre-filled with 0xFFFFFFFF -> word read 0xABCDFFFF. Byte load 0x33 -> 0x000000AB (zero-extended).
- Address wrap with ADDR_W=10: store to 0x1000 then load 0x0000 -> same data.
- Reset asserted during BUSY of a store to 0x40 -> next cycle IDLE, o_stall=0, o_valid=0, and a later load of 0x40 returns the old contents.
- With DMEM_ALIGN_CHECK_EN, word store to 0x41:
  - o_misaligned=1 in DONE;
  - word 0x40 unchanged.
- Without DMEM_ALIGN_CHECK_EN, the same access writes word 0x40 and o_misaligned stays 0.
